// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: transmit-side byte queue feeding a UART transmitter.
// Buffers up to DEPTH bytes from user logic and launches them one at a time
// over the TX_Data/transmit/busy handshake. It also flags dropped writes and
// transmitters that never answer a start request.
module uart_tx_fifo #(
    parameter int DATA_WIDTH  = 8,
    parameter int DEPTH       = 16,
    parameter int ADDR_WIDTH  = 4,
    parameter int REQ_TIMEOUT = 65535
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  wr_en,
    output logic                  full,
    output logic                  empty,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    output logic                  tx_timeout,
    output logic [DATA_WIDTH-1:0] TX_Data,
    output logic                  transmit,
    input  logic                  busy
);

    // The request timer only has to reach REQ_TIMEOUT-1.
    localparam int                    TMR_WIDTH  = (REQ_TIMEOUT > 2) ? $clog2(REQ_TIMEOUT) : 1;
    localparam logic [TMR_WIDTH-1:0]  TMR_LAST   = TMR_WIDTH'(REQ_TIMEOUT - 1);
    localparam logic [ADDR_WIDTH:0]   COUNT_FULL = (ADDR_WIDTH + 1)'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_ACTIVE
    } state_t;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic                  busy_meta_q, busy_s_q;
    state_t                state_q, state_d;
    logic [TMR_WIDTH-1:0]  tmr_q, tmr_d;
    logic [DATA_WIDTH-1:0] tx_data_q, tx_data_d;
    logic                  transmit_q, transmit_d;
    logic                  overflow_q, overflow_d;
    logic                  tx_timeout_q, tx_timeout_d;
    logic                  push, pop;

    // Status flags come straight from the registered occupancy counter.
    assign full  = (count_q == COUNT_FULL);
    assign empty = (count_q == '0);

    // Next-state logic for the queue bookkeeping and the launcher FSM.
    always_comb begin
        // NOTE: every signal gets a default here so no path leaves it unassigned (no latches).
        push         = wr_en && !full;
        pop          = 1'b0;
        overflow_d   = wr_en && full;
        tx_timeout_d = 1'b0;
        state_d      = state_q;
        tmr_d        = tmr_q;
        tx_data_d    = tx_data_q;

        case (state_q)
            ST_IDLE: begin
                if (!empty && !busy_s_q) begin
                    pop       = 1'b1;
                    tx_data_d = mem_q[rd_ptr_q];
                    tmr_d     = '0;
                    state_d   = ST_REQ;
                end
            end
            ST_REQ: begin
                if (busy_s_q) begin
                    state_d = ST_ACTIVE;
                end else if (tmr_q == TMR_LAST) begin
                    // Transmitter never answered: drop this byte, no retry.
                    tx_timeout_d = 1'b1;
                    state_d      = ST_IDLE;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            ST_ACTIVE: begin
                if (!busy_s_q) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;

        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        transmit_d = (state_d == ST_REQ);
    end

    // Control state, synchronizer and registered outputs.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (reset) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            busy_meta_q  <= 1'b0;
            busy_s_q     <= 1'b0;
            state_q      <= ST_IDLE;
            tmr_q        <= '0;
            tx_data_q    <= '0;
            transmit_q   <= 1'b0;
            overflow_q   <= 1'b0;
            tx_timeout_q <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            busy_meta_q  <= busy;
            busy_s_q     <= busy_meta_q;
            state_q      <= state_d;
            tmr_q        <= tmr_d;
            tx_data_q    <= tx_data_d;
            transmit_q   <= transmit_d;
            overflow_q   <= overflow_d;
            tx_timeout_q <= tx_timeout_d;
        end
    end

    // Byte storage written on every accepted push.
    always_ff @(posedge clk) begin
        // NOTE: the array is not reset; count and pointers alone decide which entries are valid.
        if (push) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    assign count      = count_q;
    assign overflow   = overflow_q;
    assign tx_timeout = tx_timeout_q;
    assign TX_Data    = tx_data_q;
    assign transmit   = transmit_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: directed, self-checking bench for uart_tx_fifo.
// Built with REQ_TIMEOUT=8 so the timeout path is reachable in a short run.
// A small busy model answers each start request 3 cycles after transmit rises.
module tb_uart_tx_fifo;

    logic       clk;
    logic       reset;
    logic [7:0] wr_data;
    logic       wr_en;
    logic       full;
    logic       empty;
    logic [4:0] count;
    logic       overflow;
    logic       tx_timeout;
    logic [7:0] TX_Data;
    logic       transmit;
    logic       busy;

    logic       busy_manual;
    logic       busy_model;
    logic       model_en;
    int         busy_hold;

    int n_checks = 0;
    int n_errors = 0;

    // Observed traffic, recorded on the falling edge.
    logic       transmit_prev = 1'b0;
    logic [7:0] launched [$];
    int         overflow_cnt = 0;
    int         timeout_cnt  = 0;

    typedef struct {
        logic       wr_en;
        logic [7:0] wr_data;
        logic [4:0] exp_count;
        logic       exp_full;
        logic       exp_empty;
        logic       exp_overflow;
    } vec_t;

    vec_t vecs [18];

    assign busy = model_en ? busy_model : busy_manual;

    uart_tx_fifo #(
        .DATA_WIDTH (8),
        .DEPTH      (16),
        .ADDR_WIDTH (4),
        .REQ_TIMEOUT(8)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .wr_data   (wr_data),
        .wr_en     (wr_en),
        .full      (full),
        .empty     (empty),
        .count     (count),
        .overflow  (overflow),
        .tx_timeout(tx_timeout),
        .TX_Data   (TX_Data),
        .transmit  (transmit),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record every launch and every status pulse.
    always @(negedge clk) begin
        if (transmit === 1'b1 && transmit_prev !== 1'b1) launched.push_back(TX_Data);
        if (overflow === 1'b1) overflow_cnt <= overflow_cnt + 1;
        if (tx_timeout === 1'b1) timeout_cnt <= timeout_cnt + 1;
        transmit_prev <= transmit;
    end

    // Transmitter model: raise busy 3 edges after seeing transmit, hold busy_hold edges.
    initial begin
        busy_model = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            if (model_en && transmit === 1'b1 && !busy_model) begin
                repeat (3) @(posedge clk);
                #2 busy_model = 1'b1;
                repeat (busy_hold) @(posedge clk);
                #2 busy_model = 1'b0;
            end
        end
    end

    // Global time limit.
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic write_byte(input logic [7:0] d);
        wr_en   = 1'b1;
        wr_data = d;
        tick();
        wr_en   = 1'b0;
    endtask

    // Tick until transmit equals level; cycles = -1 if the budget expires.
    task automatic wait_transmit(input logic level, input int budget, output int cycles);
        cycles = 0;
        while (transmit !== level && cycles < budget) begin
            tick();
            cycles++;
        end
        if (transmit !== level) cycles = -1;
    endtask

    task automatic wait_launched(input int target, input int budget, output logic ok);
        int n;
        n = 0;
        while (launched.size() < target && n < budget) begin
            tick();
            n++;
        end
        ok = (launched.size() >= target);
    endtask

    initial begin
        int         c;
        int         base;
        int         ovf_base;
        int         to_base;
        logic       ok;
        logic [7:0] exp_q [$];
        logic [7:0] d;

        // Burst table: 16 accepted writes, one dropped write, one idle cycle.
        for (int i = 0; i < 18; i++) begin
            vecs[i].wr_en        = (i < 17);
            vecs[i].wr_data      = (i < 16) ? 8'(i) : 8'hFF;
            vecs[i].exp_count    = (i < 16) ? 5'(i + 1) : 5'd16;
            vecs[i].exp_full     = (i >= 15);
            vecs[i].exp_empty    = 1'b0;
            vecs[i].exp_overflow = (i == 16);
        end

        reset       = 1'b1;
        wr_en       = 1'b0;
        wr_data     = 8'h00;
        busy_manual = 1'b0;
        model_en    = 1'b0;
        busy_hold   = 20;

        // ---- Reset, then idle ----
        repeat (3) tick();
        check("reset count", 32'(count), 32'd0);
        check("reset empty", 32'(empty), 32'd1);
        check("reset full", 32'(full), 32'd0);
        check("reset TX_Data", 32'(TX_Data), 32'h00);
        check("reset transmit", 32'(transmit), 32'd0);
        check("reset overflow", 32'(overflow), 32'd0);
        check("reset tx_timeout", 32'(tx_timeout), 32'd0);
        reset = 1'b0;
        c = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (transmit !== 1'b0) c++;
        end
        check("idle transmit-high cycles", 32'(c), 32'd0);
        check("idle launches", 32'(launched.size()), 32'd0);

        // ---- Single byte ----
        model_en  = 1'b1;
        busy_hold = 20;
        to_base   = timeout_cnt;
        write_byte(8'hA5);
        check("single count after write", 32'(count), 32'd1);
        check("single empty after write", 32'(empty), 32'd0);
        tick();
        check("single TX_Data", 32'(TX_Data), 32'hA5);
        check("single transmit", 32'(transmit), 32'd1);
        check("single count after pop", 32'(count), 32'd0);
        check("single empty after pop", 32'(empty), 32'd1);
        // busy at +3 edges, busy_s 2 edges later, transmit falls on the next edge.
        wait_transmit(1'b0, 20, c);
        check("single transmit high edges", 32'(c), 32'd6);
        check("single TX_Data held", 32'(TX_Data), 32'hA5);
        repeat (40) tick();
        check("single final count", 32'(count), 32'd0);
        check("single no timeout", 32'(timeout_cnt - to_base), 32'd0);

        // ---- Burst of 16 plus a dropped write while busy ----
        model_en    = 1'b0;
        busy_manual = 1'b1;
        repeat (3) tick();
        ovf_base = overflow_cnt;
        for (int i = 0; i < 18; i++) begin
            wr_en   = vecs[i].wr_en;
            wr_data = vecs[i].wr_data;
            tick();
            check($sformatf("burst row %0d {count,full,empty,ovf,transmit}", i),
                  {24'd0, count, full, empty, overflow, transmit},
                  {24'd0, vecs[i].exp_count, vecs[i].exp_full, vecs[i].exp_empty,
                   vecs[i].exp_overflow, 1'b0});
        end
        wr_en = 1'b0;
        check("burst overflow pulses", 32'(overflow_cnt - ovf_base), 32'd1);
        base      = launched.size();
        busy_hold = 2;
        model_en  = 1'b1;
        wait_launched(base + 16, 1000, ok);
        check("burst drain completed", 32'(ok), 32'd1);
        for (int i = 0; i < 16; i++) begin
            if (base + i < launched.size())
                check($sformatf("burst byte %0d", i), 32'(launched[base + i]), 32'(i));
        end
        repeat (30) tick();
        check("burst drained count", 32'(count), 32'd0);
        check("burst no extra launch", 32'(launched.size() - base), 32'd16);

        // ---- Write on full in the same cycle as a pop, then wrap ----
        model_en    = 1'b0;
        busy_manual = 1'b1;
        repeat (3) tick();
        for (int i = 0; i < 16; i++) write_byte(8'h20 + 8'(i));
        check("pop-write full", 32'(full), 32'd1);
        base        = launched.size();
        busy_manual = 1'b0;
        tick();
        tick();
        wr_en   = 1'b1;
        wr_data = 8'hEE;
        tick();
        wr_en = 1'b0;
        check("pop-write overflow", 32'(overflow), 32'd1);
        check("pop-write count", 32'(count), 32'd15);
        check("pop-write transmit", 32'(transmit), 32'd1);
        check("pop-write TX_Data", 32'(TX_Data), 32'h20);
        model_en = 1'b1;
        for (int i = 0; i < 16; i++) exp_q.push_back(8'h20 + 8'(i));
        tick();
        check("pop-write overflow single pulse", 32'(overflow), 32'd0);
        for (int i = 0; i < 40; i++) begin
            d = 8'h80 + 8'(i * 7);
            exp_q.push_back(d);
            write_byte(d);
            check($sformatf("wrap write %0d no overflow", i), 32'(overflow), 32'd0);
            repeat (11) tick();
        end
        wait_launched(base + 56, 2000, ok);
        check("wrap drain completed", 32'(ok), 32'd1);
        for (int i = 0; i < 56; i++) begin
            if (base + i < launched.size())
                check($sformatf("wrap byte %0d", i), 32'(launched[base + i]), 32'(exp_q[i]));
        end
        repeat (40) tick();
        check("wrap final empty", 32'(empty), 32'd1);

        // ---- Timeout with busy held low ----
        model_en    = 1'b0;
        busy_manual = 1'b0;
        repeat (5) tick();
        base    = launched.size();
        to_base = timeout_cnt;
        write_byte(8'h51);
        wr_en   = 1'b1;
        wr_data = 8'h52;
        tick();
        wr_en = 1'b0;
        check("timeout first transmit", 32'(transmit), 32'd1);
        check("timeout first TX_Data", 32'(TX_Data), 32'h51);
        repeat (7) tick();
        check("timeout not yet {transmit,tx_timeout}", {30'd0, transmit, tx_timeout}, 32'b10);
        tick();
        check("timeout pulse", 32'(tx_timeout), 32'd1);
        check("timeout transmit dropped", 32'(transmit), 32'd0);
        tick();
        check("timeout pulse single cycle", 32'(tx_timeout), 32'd0);
        check("timeout next transmit", 32'(transmit), 32'd1);
        check("timeout next TX_Data", 32'(TX_Data), 32'h52);
        check("timeout count", 32'(count), 32'd0);
        repeat (7) tick();
        check("timeout second not yet", 32'(tx_timeout), 32'd0);
        tick();
        check("timeout second pulse", 32'(tx_timeout), 32'd1);
        repeat (20) tick();
        check("timeout pulses total", 32'(timeout_cnt - to_base), 32'd2);
        check("timeout launches", 32'(launched.size() - base), 32'd2);
        if (launched.size() >= base + 2) begin
            check("timeout launch 0", 32'(launched[base]), 32'h51);
            check("timeout launch 1", 32'(launched[base + 1]), 32'h52);
        end
        check("timeout idle transmit", 32'(transmit), 32'd0);

        // ---- Reset while in REQ with 5 queued ----
        for (int i = 0; i < 6; i++) write_byte(8'h71 + 8'(i));
        check("mid-reset pre count", 32'(count), 32'd5);
        check("mid-reset pre transmit", 32'(transmit), 32'd1);
        base  = launched.size();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mid-reset transmit", 32'(transmit), 32'd0);
        check("mid-reset count", 32'(count), 32'd0);
        check("mid-reset empty", 32'(empty), 32'd1);
        check("mid-reset full", 32'(full), 32'd0);
        check("mid-reset TX_Data", 32'(TX_Data), 32'h00);
        c = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (transmit !== 1'b0) c++;
        end
        check("post-reset transmit-high cycles", 32'(c), 32'd0);
        check("post-reset launches", 32'(launched.size() - base), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Transmit-side byte queue and launcher sitting directly upstream of the UART transmitter. It accepts bytes from user logic at system-clock rate, buffers up to DEPTH entries, and hands them one at a time to the transmitter over the `TX_Data`/`transmit`/`busy` handshake. Its purpose is to decouple bursty producers from the slow baud-rate serializer. It also flags dropped writes and unresponsive transmitters.

## Interface

Parameters:
- DATA_WIDTH, 8, byte width; matches transmitter `TX_Data`.
- DEPTH, 16, queue entries; power of two, at least 2.
- ADDR_WIDTH, 4, log2(DEPTH).
- REQ_TIMEOUT, 65535, maximum `clk` cycles `transmit` is held waiting for `busy` to rise.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- wr_data  input  DATA_WIDTH  byte to enqueue.
- wr_en  input  1  enqueue request; sampled every cycle.
- full  output  1  queue holds DEPTH entries.
- empty  output  1  queue holds 0 entries.
- count  output  ADDR_WIDTH+1  current occupancy, 0..DEPTH.
- overflow  output  1  one-cycle pulse: write dropped because the queue was full.
- tx_timeout  output  1  one-cycle pulse: REQ_TIMEOUT expired without `busy`.
- TX_Data  output  DATA_WIDTH  byte presented to the transmitter.
- transmit  output  1  start request to the transmitter (level).
- busy  input  1  transmitter busy; may be asynchronous to `clk`.

## Operation

- Storage: DEPTH×DATA_WIDTH register array. Write and read pointers are ADDR_WIDTH bits and wrap modulo DEPTH. `count` is an explicit counter.
- Write: if `wr_en && !full`, store `wr_data` at wr_ptr, then increment wr_ptr. If `wr_en && full`, drop the data and pulse `overflow`.
  - `full` is the registered state of the current cycle, so a pop in the same cycle does not free space for that write.
- Simultaneous accepted write and pop: `count` is unchanged and both pointers advance.
- `busy` passes through a 2-flop synchronizer (`busy_s`) before any use.
- Launcher FSM:
  - IDLE: when `!empty && !busy_s`, pop the head into the `TX_Data` register, increment rd_ptr, decrement `count`, and go to REQ.
  - REQ: `transmit`=1. If `busy_s`=1, go to ACTIVE. If the timeout counter reaches REQ_TIMEOUT-1, pulse `tx_timeout`, go to IDLE, and discard the byte (no retry).
  - ACTIVE: `transmit`=0. When `busy_s`=0, go to IDLE.
- `transmit` is a registered output, high only in REQ.
- `TX_Data` holds its value from the pop until the next pop.
- The timeout counter clears on entry to REQ and increments each cycle in REQ. Its width is sized to REQ_TIMEOUT.
- Reset values, applied at the rising edge with `reset`=1:
  - pointers 0, `count` 0, `empty` 1, `full` 0;
  - `TX_Data` 0, `transmit` 0, `overflow` 0, `tx_timeout` 0;
  - synchronizer flops 0, FSM in IDLE.
- Reset mid-transfer: all queued bytes are lost and `transmit` drops at that edge. Any frame already started by the transmitter is not this block's concern.

## Timing

- Accepted write at edge N: `count`, `empty`, and `full` reflect it after edge N.
- Earliest launch: a byte written at edge N into an empty queue with `busy_s`=0 is popped at edge N+1. `TX_Data` and `transmit` are valid after edge N+1.
- A `busy` rise reaches `busy_s` 2 edges later. `transmit` falls on the edge after `busy_s` is sampled high.
- Back-to-back bytes: the next pop occurs at the earliest 1 cycle after `busy_s` returns to 0.
- `full` asserts after the DEPTH-th accepted write with no pops. `empty` asserts after the pop of the last entry.
- Pointer wrap from DEPTH-1 to 0 is seamless; `count` alone distinguishes full from empty.
- `overflow` and `tx_timeout` are single-cycle pulses and never stretch, even on consecutive events. Each event pulses its own cycle.

## Test plan

- Reset, then idle: all outputs at their reset values; `transmit` stays 0 for 100 cycles with `busy`=0.
- Single byte: write 0xA5 with the `busy` model answering 3 cycles after `transmit` rises and holding for 20 cycles.
  - `TX_Data`=0xA5 and `transmit`=1 one edge after the write.
  - `transmit` falls after `busy_s` goes high.
  - `count` returns to 0.
- Burst of 16 bytes 0x00..0x0F while `busy`=1, then a 17th write of 0xFF.
  - `full`=1 after the 16th write.
  - `overflow` pulses once and 0xFF is dropped.
  - Releasing `busy` yields bytes 0x00..0x0F in order.
- Write on a full queue in the same cycle as a pop: the write is rejected and `overflow`=1, `count` goes from 16 to 15, and pointer wrap remains correct over 40 further mixed writes.
- `busy` held at 0 with REQ_TIMEOUT=8: `tx_timeout` pulses 8 cycles after `transmit` rises, `transmit` returns to 0, the next queued byte launches, and no byte repeats.
- Reset asserted while in REQ with 5 queued: `transmit`=0, `count`=0, `empty`=1 after that edge, and no further launch occurs.
